// File: rtl/param_sp_ram.sv
// Single-port RAM with per-byte write enables, pipelined reads (RD_LAT 1 or 2) and an out-of-range error pulse.
// Optional macro SP_RAM_INIT_CLEAR_EN adds an INIT state that zeroes every word after reset before accepting requests.
module param_sp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                err
);
    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_ready;
    logic              w_acc;
    logic              w_oob;
    logic              w_init_we;
    logic [ADDR_W-1:0] w_init_addr;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [BE_W-1:0]   w_mem_be;
    logic              w_rerr;

    logic              r_vld_p0;
    logic              r_err_p0;
    logic [DATA_W-1:0] r_data_p0;
    logic              r_werr;

`ifdef SP_RAM_INIT_CLEAR_EN
    typedef enum logic {ST_INIT, ST_IDLE} state_t;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_init_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_init_we) r_init_cnt <= r_init_cnt + ADDR_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_init_we   = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_we = 1'b1;
                if (r_init_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = ST_IDLE;
            end
            default: w_ready = 1'b1;
        endcase
    end

    assign w_init_addr = r_init_cnt;
`else
    logic r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ready <= 1'b0;
        else     r_ready <= 1'b1;
    end

    assign w_ready     = r_ready;
    assign w_init_we   = 1'b0;
    assign w_init_addr = '0;
`endif

    assign ready = w_ready;
    assign w_acc = req & w_ready;
    assign w_oob = ({1'b0, addr} >= (ADDR_W + 1)'(DEPTH));

    // The clearing sweep and user writes share the single write port; ready=0 keeps them exclusive.
    assign w_mem_we    = w_init_we | (w_acc & we & ~w_oob);
    assign w_mem_addr  = w_init_we ? w_init_addr : addr;
    assign w_mem_wdata = w_init_we ? '0 : wdata;
    assign w_mem_be    = w_init_we ? '1 : be;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (w_mem_be[b]) r_mem[w_mem_addr][8*b +: 8] <= w_mem_wdata[8*b +: 8];
            end
        end
    end

    // Stage p0: array read at the accept edge, so a write one cycle earlier is already visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p0  <= 1'b0;
            r_err_p0  <= 1'b0;
            r_werr    <= 1'b0;
            r_data_p0 <= '0;
        end else begin
            r_vld_p0 <= w_acc & ~we;
            r_err_p0 <= w_acc & ~we & w_oob;
            r_werr   <= w_acc & we & w_oob;
            if (w_acc & ~we) r_data_p0 <= w_oob ? '0 : r_mem[addr];
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_vld_p1;
            logic              r_err_p1;
            logic [DATA_W-1:0] r_data_p1;

            // Stage p1: data only advances with a valid beat so rdata holds between reads.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld_p1  <= 1'b0;
                    r_err_p1  <= 1'b0;
                    r_data_p1 <= '0;
                end else begin
                    r_vld_p1 <= r_vld_p0;
                    r_err_p1 <= r_err_p0;
                    if (r_vld_p0) r_data_p1 <= r_data_p0;
                end
            end

            assign rvalid = r_vld_p1;
            assign rdata  = r_data_p1;
            assign w_rerr = r_err_p1;
        end else begin : g_lat1
            assign rvalid = r_vld_p0;
            assign rdata  = r_data_p0;
            assign w_rerr = r_err_p0;
        end
    endgenerate

    assign err = w_rerr | r_werr;
endmodule

// File: tb/tb_param_sp_ram.sv
// Directed bench for param_sp_ram: a 32-bit RD_LAT=2 DEPTH=100 instance and an 8-bit RD_LAT=1 DEPTH=128 instance.
module tb_param_sp_ram;
    logic clk;
    logic rst = 1'b1;

    logic        a_req = 1'b0, a_we = 1'b0;
    logic [6:0]  a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic [3:0]  a_be = '0;
    logic        a_ready, a_rvalid, a_err;
    logic [31:0] a_rdata;

    logic        b_req = 1'b0, b_we = 1'b0;
    logic [6:0]  b_addr = '0;
    logic [7:0]  b_wdata = '0;
    logic [0:0]  b_be = '0;
    logic        b_ready, b_rvalid, b_err;
    logic [7:0]  b_rdata;

    int n_total = 0;
    int n_bad   = 0;

    param_sp_ram #(.DATA_W(32), .ADDR_W(7), .DEPTH(100), .RD_LAT(2)) u_dut_a (
        .clk(clk), .rst(rst), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata), .be(a_be),
        .ready(a_ready), .rdata(a_rdata), .rvalid(a_rvalid), .err(a_err)
    );

    param_sp_ram #(.DATA_W(8), .ADDR_W(7), .DEPTH(128), .RD_LAT(1)) u_dut_b (
        .clk(clk), .rst(rst), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata), .be(b_be),
        .ready(b_ready), .rdata(b_rdata), .rvalid(b_rvalid), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int exp_a, input int exp_b);
        int za, zb, seen;
        za = 0; zb = 0; seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (!a_ready) za++;
            if (!b_ready) zb++;
            if (a_rvalid || b_rvalid || a_err || b_err) seen++;
            if (a_ready && b_ready) break;
            step();
        end
        chk({tag, "_ready_a"}, 32'(a_ready), 1);
        chk({tag, "_ready_b"}, 32'(b_ready), 1);
        chk({tag, "_lowcyc_a"}, za, exp_a);
        chk({tag, "_lowcyc_b"}, zb, exp_b);
        chk({tag, "_no_rvalid_err"}, seen, 0);
    endtask

    task automatic a_write(input logic [6:0] ad, input logic [31:0] d, input logic [3:0] m);
        a_req = 1'b1; a_we = 1'b1; a_addr = ad; a_wdata = d; a_be = m;
        step();
        a_req = 1'b0; a_we = 1'b0;
    endtask

    task automatic a_read(input string tag, input logic [6:0] ad, input logic [31:0] exp_d, input logic exp_e);
        a_req = 1'b1; a_we = 1'b0; a_addr = ad;
        step();
        a_req = 1'b0;
        chk({tag, "_early_vld"}, 32'(a_rvalid), 0);
        step();
        chk({tag, "_vld"}, 32'(a_rvalid), 1);
        chk({tag, "_data"}, a_rdata, exp_d);
        chk({tag, "_err"}, 32'(a_err), 32'(exp_e));
        step();
        chk({tag, "_vld_end"}, 32'(a_rvalid), 0);
        chk({tag, "_hold"}, a_rdata, exp_d);
    endtask

    initial begin
        int exp_low_a, exp_low_b;
        logic [31:0] exp_retain;
`ifdef SP_RAM_INIT_CLEAR_EN
        exp_low_a = 100; exp_low_b = 128; exp_retain = 32'h0;
`else
        exp_low_a = 1;   exp_low_b = 1;   exp_retain = 32'hAA22CC44;
`endif
        repeat (3) step();
        chk("rst_ready_a", 32'(a_ready), 0);
        chk("rst_ready_b", 32'(b_ready), 0);
        chk("rst_rvalid_a", 32'(a_rvalid), 0);
        chk("rst_err_b", 32'(b_err), 0);
        chk("rst_rdata_a", a_rdata, 0);
        rst = 1'b0;
        wait_ready("boot", exp_low_a, exp_low_b);

`ifdef SP_RAM_INIT_CLEAR_EN
        b_req = 1'b1; b_we = 1'b0; b_addr = 7'd5;
        step();
        b_req = 1'b0;
        chk("clear_vld", 32'(b_rvalid), 1);
        chk("clear_data", 32'(b_rdata), 0);
        step();
`endif

        // Byte-enable merge, then read the cycle right after the last write.
        a_write(7'd3, 32'hAABBCCDD, 4'hF);
        chk("wr_no_rvalid", 32'(a_rvalid), 0);
        chk("wr_no_err", 32'(a_err), 0);
        a_write(7'd3, 32'h11223344, 4'h5);
        a_read("be_merge", 7'd3, 32'hAA22CC44, 1'b0);
        a_write(7'd3, 32'hFFFFFFFF, 4'h0);
        a_read("be_zero", 7'd3, 32'hAA22CC44, 1'b0);

        // Out-of-range accesses must not alias onto addr 20.
        a_write(7'd20, 32'h12345678, 4'hF);
        a_write(7'd120, 32'h00000055, 4'hF);
        chk("oob_wr_err", 32'(a_err), 1);
        step();
        chk("oob_wr_err_end", 32'(a_err), 0);
        a_read("oob_rd", 7'd120, 32'h0, 1'b1);
        a_read("alias20", 7'd20, 32'h12345678, 1'b0);

        // Preload 0x10..0x13 then four back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            b_req = 1'b1; b_we = 1'b1; b_addr = 7'(i); b_wdata = 8'(8'h10 + i); b_be = 1'b1;
            step();
        end
        b_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_addr = 7'(i);
            step();
            chk($sformatf("b2b_vld%0d", i), 32'(b_rvalid), 1);
            chk($sformatf("b2b_data%0d", i), 32'(b_rdata), 32'(8'h10 + i));
        end
        b_req = 1'b0;
        step();
        chk("b2b_vld_end", 32'(b_rvalid), 0);
        chk("b2b_hold", 32'(b_rdata), 32'h13);

        // Reset while a read is in flight in the two-stage pipeline.
        a_req = 1'b1; a_we = 1'b0; a_addr = 7'd3;
        step();
        a_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_rvalid", 32'(a_rvalid), 0);
        chk("midrst_rdata", a_rdata, 0);
        chk("midrst_ready", 32'(a_ready), 0);
        chk("midrst_rdata_b", 32'(b_rdata), 0);
        step();
        chk("midrst_rvalid2", 32'(a_rvalid), 0);
        rst = 1'b0;
        wait_ready("rerun", exp_low_a, exp_low_b);
        a_read("retain", 7'd3, exp_retain, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
